// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter onto a single memory slave, one transaction outstanding at a time.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise master 1 wins ties.
module wb_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_wb_stb,
  input  logic [31:0] i_m0_wb_addr,
  input  logic [31:0] i_m0_wb_data,
  input  logic        i_m0_wb_we,
  input  logic [2:0]  i_m0_wb_sel,
  output logic [31:0] o_m0_wb_data,
  output logic        o_m0_wb_ack,
  output logic        o_m0_wb_stall,
  input  logic        i_m1_wb_stb,
  input  logic [31:0] i_m1_wb_addr,
  input  logic [31:0] i_m1_wb_data,
  input  logic        i_m1_wb_we,
  input  logic [2:0]  i_m1_wb_sel,
  output logic [31:0] o_m1_wb_data,
  output logic        o_m1_wb_ack,
  output logic        o_m1_wb_stall,
  output logic        o_s_wb_stb,
  output logic [31:0] o_s_wb_addr,
  output logic [31:0] o_s_wb_data,
  output logic        o_s_wb_we,
  output logic [2:0]  o_s_wb_sel,
  input  logic [31:0] i_s_wb_data,
  input  logic        i_s_wb_ack,
  input  logic        i_s_wb_stall,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic        stb_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [2:0]  sel_q;
  logic [1:0]  grant_q;

  logic        idle_s;
  logic        tie_m1_s;
  logic        win0_s;
  logic        win1_s;
  logic        ack_s;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // last_q = 1 means master 1 was granted last, so master 0 takes the next tie.
  logic        last_q;
  assign tie_m1_s = ~last_q;
`else
  assign tie_m1_s = 1'b1;
`endif

  // Arbitration decode and the reset-gated completion strobe
  always_comb begin
    idle_s = (state_q == ST_IDLE);
    win1_s = idle_s & i_m1_wb_stb & (~i_m0_wb_stb | tie_m1_s);
    win0_s = idle_s & i_m0_wb_stb & ~win1_s;
    ack_s  = (state_q == ST_WAIT) & i_s_wb_ack & ~i_reset;
  end

  assign o_m0_wb_stall = ~idle_s | (i_m0_wb_stb & win1_s);
  assign o_m1_wb_stall = ~idle_s | (i_m1_wb_stb & win0_s);
  assign o_m0_wb_ack   = ack_s & grant_q[0];
  assign o_m1_wb_ack   = ack_s & grant_q[1];
  assign o_m0_wb_data  = o_m0_wb_ack ? i_s_wb_data : 32'h0000_0000;
  assign o_m1_wb_data  = o_m1_wb_ack ? i_s_wb_data : 32'h0000_0000;

  assign o_s_wb_stb    = stb_q;
  assign o_s_wb_addr   = addr_q;
  assign o_s_wb_data   = data_q;
  assign o_s_wb_we     = we_q;
  assign o_s_wb_sel    = sel_q;
  assign o_grant       = grant_q;

  // Transaction FSM with registered slave request and grant
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      stb_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      we_q    <= 1'b0;
      sel_q   <= 3'b000;
      grant_q <= 2'b00;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win0_s | win1_s) begin
            state_q <= ST_REQ;
            stb_q   <= 1'b1;
            grant_q <= {win1_s, win0_s};
            addr_q  <= win1_s ? i_m1_wb_addr : i_m0_wb_addr;
            data_q  <= win1_s ? i_m1_wb_data : i_m0_wb_data;
            we_q    <= win1_s ? i_m1_wb_we   : i_m0_wb_we;
            sel_q   <= win1_s ? i_m1_wb_sel  : i_m0_wb_sel;
`ifdef WB_ARB_ROUND_ROBIN_EN
            last_q  <= win1_s;
`endif
          end
        end
        ST_REQ: begin
          if (!i_s_wb_stall) begin
            state_q <= ST_WAIT;
            stb_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_s_wb_ack) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          stb_q   <= 1'b0;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model (busy / sent-to-slave / owner).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_stb;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdat [2];
  logic [1:0]  m_we;
  logic [2:0]  m_sel  [2];
  logic [31:0] d_data0, d_data1;
  logic [1:0]  d_ack, d_stall;
  logic        s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [2:0]  s_sel_o;
  logic [31:0] s_data;
  logic        s_ack, s_stall;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;
  int ack_seen = 0;
  int stb_seen = 0;

  // Reference model state
  bit          mdl_busy, mdl_sent, mdl_last;
  int          mdl_owner;
  logic [31:0] mdl_addr, mdl_data;
  logic        mdl_we;
  logic [2:0]  mdl_sel;
  bit   [1:0]  acc;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_wb_stb(m_stb[0]), .i_m0_wb_addr(m_addr[0]), .i_m0_wb_data(m_wdat[0]),
    .i_m0_wb_we(m_we[0]), .i_m0_wb_sel(m_sel[0]),
    .o_m0_wb_data(d_data0), .o_m0_wb_ack(d_ack[0]), .o_m0_wb_stall(d_stall[0]),
    .i_m1_wb_stb(m_stb[1]), .i_m1_wb_addr(m_addr[1]), .i_m1_wb_data(m_wdat[1]),
    .i_m1_wb_we(m_we[1]), .i_m1_wb_sel(m_sel[1]),
    .o_m1_wb_data(d_data1), .o_m1_wb_ack(d_ack[1]), .o_m1_wb_stall(d_stall[1]),
    .o_s_wb_stb(s_stb_o), .o_s_wb_addr(s_addr_o), .o_s_wb_data(s_data_o),
    .o_s_wb_we(s_we_o), .o_s_wb_sel(s_sel_o),
    .i_s_wb_data(s_data), .i_s_wb_ack(s_ack), .i_s_wb_stall(s_stall),
    .o_grant(grant)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner among requesting masters; -1 when nobody requests.
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      return mdl_last ? 0 : 1;
`else
      return 1;
`endif
    end else if (r1) begin
      return 1;
    end else if (r0) begin
      return 0;
    end else begin
      return -1;
    end
  endfunction

  task automatic set_m(input int n, input logic stb, input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic [2:0] sel);
    m_stb[n] = stb; m_addr[n] = a; m_wdat[n] = d; m_we[n] = we; m_sel[n] = sel;
  endtask

  task automatic check_cycle();
    int   w;
    logic ea;
    logic [31:0] gd;
    @(negedge clk);
    w = mdl_busy ? -1 : pick(m_stb[0], m_stb[1]);
    for (int n = 0; n < 2; n++) begin
      ea = mdl_busy && mdl_sent && s_ack && (mdl_owner == n) && !rst;
      gd = (n == 0) ? d_data0 : d_data1;
      check_val($sformatf("m%0d_stall", n), {31'd0, d_stall[n]},
                {31'd0, (mdl_busy || (m_stb[n] && w != n))});
      check_val($sformatf("m%0d_ack", n), {31'd0, d_ack[n]}, {31'd0, ea});
      check_val($sformatf("m%0d_rdata", n), gd, ea ? s_data : 32'h0);
    end
    check_val("s_stb", {31'd0, s_stb_o}, {31'd0, (mdl_busy && !mdl_sent)});
    check_val("grant", {30'd0, grant},
              {30'd0, (mdl_busy ? (mdl_owner == 0 ? 2'b01 : 2'b10) : 2'b00)});
    if (mdl_busy && !mdl_sent) begin
      check_val("s_addr", s_addr_o, mdl_addr);
      check_val("s_wdata", s_data_o, mdl_data);
      check_val("s_we", {31'd0, s_we_o}, {31'd0, mdl_we});
      check_val("s_sel", {29'd0, s_sel_o}, {29'd0, mdl_sel});
    end
    ack_seen += int'(d_ack[0]) + int'(d_ack[1]);
    stb_seen += int'(s_stb_o);
  endtask

  task automatic advance();
    int w;
    @(posedge clk);
    acc = 2'b00;
    if (rst) begin
      mdl_busy = 1'b0; mdl_sent = 1'b0; mdl_last = 1'b1;
      mdl_addr = 32'h0; mdl_data = 32'h0; mdl_we = 1'b0; mdl_sel = 3'b000;
    end else if (!mdl_busy) begin
      w = pick(m_stb[0], m_stb[1]);
      if (w >= 0) begin
        mdl_busy = 1'b1; mdl_sent = 1'b0; mdl_owner = w; mdl_last = (w == 1);
        mdl_addr = m_addr[w]; mdl_data = m_wdat[w]; mdl_we = m_we[w]; mdl_sel = m_sel[w];
        acc[w] = 1'b1;
      end
    end else if (!mdl_sent) begin
      if (!s_stall) mdl_sent = 1'b1;
    end else if (s_ack) begin
      mdl_busy = 1'b0;
    end
    #1;
    for (int n = 0; n < 2; n++) if (acc[n]) m_stb[n] = 1'b0;
  endtask

  task automatic cyc();
    check_cycle();
    advance();
  endtask

  task automatic do_reset();
    m_stb = 2'b00; s_ack = 1'b0; s_stall = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] sels [5];
    sels[0] = 3'b000; sels[1] = 3'b001; sels[2] = 3'b010; sels[3] = 3'b100; sels[4] = 3'b101;
    for (int n = 0; n < 2; n++) set_m(n, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
    s_data = 32'h0; s_ack = 1'b0; s_stall = 1'b0; rst = 1'b1;
    mdl_busy = 1'b0; mdl_sent = 1'b0; mdl_last = 1'b1; mdl_owner = 0;
    advance();
    advance();
    rst = 1'b0;
    check_cycle();
    check_val("rst_grant", {30'd0, grant}, 32'd0);
    check_val("rst_s_stb", {31'd0, s_stb_o}, 32'd0);
    check_val("rst_s_addr", s_addr_o, 32'd0);
    advance();

    // m0 alone reads 0x10, slave acks two cycles after its strobe
    set_m(0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
    cyc(); cyc(); cyc();
    s_ack = 1'b1; s_data = 32'hDEADBEEF;
    check_cycle();
    check_val("s1_m0_ack", {31'd0, d_ack[0]}, 32'd1);
    check_val("s1_m0_data", d_data0, 32'hDEADBEEF);
    check_val("s1_m1_ack", {31'd0, d_ack[1]}, 32'd0);
    check_val("s1_grant", {30'd0, grant}, 32'd1);
    advance();
    s_ack = 1'b0;
    check_cycle();
    check_val("s1_grant_idle", {30'd0, grant}, 32'd0);
    advance();

    // Both masters strobe together; m1 writes 0xAB as a byte
    do_reset();
    set_m(1, 1'b1, 32'h20, 32'hAB, 1'b1, 3'b000);
    set_m(0, 1'b1, 32'h40, 32'h0, 1'b0, 3'b010);
    check_cycle();
`ifndef WB_ARB_ROUND_ROBIN_EN
    check_val("s2_m0_stall_idle", {31'd0, d_stall[0]}, 32'd1);
`endif
    advance();
    check_cycle();
`ifndef WB_ARB_ROUND_ROBIN_EN
    check_val("s2_s_data", s_data_o, 32'hAB);
    check_val("s2_s_we", {31'd0, s_we_o}, 32'd1);
    check_val("s2_grant", {30'd0, grant}, 32'd2);
`endif
    check_val("s2_m0_stall_req", {31'd0, d_stall[0]}, 32'd1);
    advance();
    cyc();
    s_ack = 1'b1; cyc(); s_ack = 1'b0;
    cyc(); cyc(); cyc();
    s_ack = 1'b1; cyc(); s_ack = 1'b0;

    // Both strobe continuously for four transactions
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_m(0, 1'b1, 32'h100 + i, 32'h0, 1'b0, 3'b010);
      set_m(1, 1'b1, 32'h200 + i, 32'h0, 1'b0, 3'b010);
      cyc();
      m_stb = 2'b11;
      check_cycle();
`ifdef WB_ARB_ROUND_ROBIN_EN
      check_val("s3_grant", {30'd0, grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
`else
      check_val("s3_grant", {30'd0, grant}, 32'd2);
`endif
      advance();
      cyc();
      s_ack = 1'b1; cyc(); s_ack = 1'b0;
    end

    // Slave stalls three cycles in REQ
    do_reset();
    set_m(0, 1'b1, 32'h300, 32'h55, 1'b1, 3'b001);
    s_stall = 1'b1;
    cyc();
    stb_seen = 0; ack_seen = 0;
    cyc(); cyc(); cyc();
    s_stall = 1'b0;
    cyc(); cyc();
    s_ack = 1'b1; cyc(); s_ack = 1'b0;
    cyc(); cyc();
    check_val("s4_stb_cycles", stb_seen, 32'd4);
    check_val("s4_ack_count", ack_seen, 32'd1);

    // Reset while waiting for the slave, then a late ack
    do_reset();
    set_m(0, 1'b1, 32'h400, 32'h0, 1'b0, 3'b010);
    cyc(); cyc();
    ack_seen = 0;
    rst = 1'b1; cyc(); rst = 1'b0;
    s_ack = 1'b1; cyc(); s_ack = 1'b0;
    check_cycle();
    check_val("s5_ack_count", ack_seen, 32'd0);
    check_val("s5_grant", {30'd0, grant}, 32'd0);
    check_val("s5_s_stb", {31'd0, s_stb_o}, 32'd0);
    advance();

    // Spurious slave ack while idle
    do_reset();
    ack_seen = 0;
    s_ack = 1'b1; cyc(); cyc(); cyc(); s_ack = 1'b0;
    check_val("s6_ack_count", ack_seen, 32'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!m_stb[n] && $urandom_range(0, 2) == 0)
          set_m(n, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), sels[$urandom_range(0, 4)]);
      end
      s_stall = ($urandom_range(0, 2) == 0);
      s_ack   = ($urandom_range(0, 2) == 0);
      s_data  = $urandom;
      rst     = ($urandom_range(0, 79) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous, active-high.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- i_clk  in  1  clock, all state updates on rising edge.
- i_reset  in  1  synchronous active-high reset.
- i_mN_wb_stb  in  1  master N request strobe (N = 0 instruction fetch, N = 1 load/store).
- i_mN_wb_addr  in  32  master N byte address.
- i_mN_wb_data  in  32  master N write data.
- i_mN_wb_we  in  1  master N write enable.
- i_mN_wb_sel  in  3  master N size code: 000 byte, 001 half, 010 word, 100 byte zero-extend, 101 half zero-extend.
- o_mN_wb_data  out  32  master N read data.
- o_mN_wb_ack  out  1  master N completion.
- o_mN_wb_stall  out  1  master N back-pressure.
- o_s_wb_stb, o_s_wb_addr[32], o_s_wb_data[32], o_s_wb_we, o_s_wb_sel[3]  out  request to the shared memory slave.
- i_s_wb_data  in  32  slave read data.
- i_s_wb_ack  in  1  slave completion.
- i_s_wb_stall  in  1  slave back-pressure.
- o_grant  out  2  one-hot owner of the current transaction (00 when idle).

Function
REQ-003 SHALL implement the states IDLE, REQ and WAIT.
REQ-004 A master request SHALL be accepted in the cycle where stb=1 and its stall=0.
REQ-005 Stall in IDLE:
- the winning master sees stall=0;
- a requesting loser sees stall=1;
- with no requests, both stalls are 0.
REQ-006 In REQ and WAIT, both master stalls SHALL be 1.
REQ-007 On acceptance, the arbiter SHALL:
- latch addr, data, we and sel of the winner;
- set o_grant to the winner;
- move to REQ.
REQ-008 In REQ:
- o_s_wb_stb=1 with the latched fields;
- if i_s_wb_stall=0 in that cycle, move to WAIT next cycle;
- otherwise hold REQ with all fields unchanged.
REQ-009 In WAIT:
- o_s_wb_stb=0;
- on i_s_wb_ack=1, drive o_mN_wb_ack=1 and o_mN_wb_data=i_s_wb_data to the owner only, combinationally in the same cycle;
- then move to IDLE and clear o_grant.
REQ-010 The non-owner master SHALL see ack=0 and data=32'h0 at all times; the owner sees data=32'h0 except in its ack cycle.
REQ-011 i_s_wb_ack SHALL be ignored in IDLE and REQ; no master ack is produced.
REQ-012 Exactly one transaction SHALL be outstanding; acceptance latency from IDLE is 0 cycles, and the slave strobe appears the cycle after acceptance.
REQ-013 After completion, the arbiter SHALL be in IDLE the next cycle and may accept a new request there (no back-to-back accept in the ack cycle).
REQ-014 The latched request fields SHALL be forwarded unmodified; the arbiter performs no address decode or size checking.

Reset
REQ-015 While i_reset=1, in the next state:
- state=IDLE, o_grant=00, latched fields=0;
- o_s_wb_stb=0, master acks=0, master data=0;
- last-grant register=1.
REQ-016 Reset in REQ or WAIT SHALL abandon the transaction: no master ack is produced, and a late slave ack is ignored (REQ-011).

Configuration
REQ-017 Macro WB_ARB_ROUND_ROBIN_EN selects the tie-break when both masters strobe in IDLE:
- defined: grant the master not granted last, recording the grant in the last-grant register (after reset, master 0 wins the first tie);
- undefined: fixed priority, master 1 always wins ties, and the last-grant register is absent.

Verification
REQ-018 The bench SHALL cover these scenarios:
- m0 alone reads addr 0x10, sel 010, slave acks with 0xDEADBEEF two cycles after strobe -> o_m0_wb_ack=1 with data 0xDEADBEEF, o_m1_wb_ack=0, o_grant 01 then 00.
- Both strobe in IDLE, macro undefined, m1 writes 0xAB sel 000 -> slave sees m1 fields; m0 stall=1 until IDLE, then m0 is served.
- Macro defined, both strobe continuously for 4 transactions -> grants alternate m0, m1, m0, m1.
- Slave holds stall=1 for 3 cycles in REQ -> o_s_wb_stb held with constant fields for 4 cycles; one ack only.
- i_reset asserted in WAIT, slave acks the cycle after -> no master ack, state IDLE, o_grant=00.
- Spurious i_s_wb_ack in IDLE -> both master acks stay 0.
